// File: rtl/par_checking_sink.sv
// par_checking_sink
//   Self-checking local sink for the parallel NoC. It sits on a router's local
//   output port. It throttles the router with an LFSR-driven busy pattern.
//   Every accepted flit is checked for the correct destination and for
//   in-order sequence numbers per source.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous reset, active-low
//   busy       out  back-pressure; the router holds its flit while this is 1
//   data       in   flit {src, seq, dest}, dest in the LSBs
//   valid      in   flit present
//   rx_count   out  accepted flits (saturating, 20 bits)
//   err_count  out  erroneous flits (saturating, 16 bits)
//   misroute   out  sticky: wrong dest or out-of-range src seen
//   seq_err    out  sticky: out-of-order sequence number seen
//   halted     out  1 while the sink is stopped after an error
//   last_flit  out  most recently accepted flit
module par_checking_sink #(
    parameter int NODE_ID      = 0,
    parameter int NUM_NODES    = 9,
    parameter int ADDR_BITS    = 4,
    parameter int PAYLOAD_SIZE = 12,
    parameter int HOSP         = 255,
    parameter int STOP_ON_ERR  = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    output logic                              busy,
    input  logic [PAYLOAD_SIZE+ADDR_BITS-1:0] data,
    input  logic                              valid,
    output logic [19:0]                       rx_count,
    output logic [15:0]                       err_count,
    output logic                              misroute,
    output logic                              seq_err,
    output logic                              halted,
    output logic [PAYLOAD_SIZE+ADDR_BITS-1:0] last_flit
);

    localparam int W   = PAYLOAD_SIZE + ADDR_BITS;
    localparam int SEQ = PAYLOAD_SIZE - ADDR_BITS;

    localparam logic [7:0] SEED   = 8'(NODE_ID + 1);
    localparam logic [7:0] HOSP_B = 8'(HOSP);

    typedef enum logic [1:0] {
        S_RESET,
        S_RUN,
        S_HALT
    } state_t;

    state_t             state_q;
    logic [7:0]         lfsr_q;
    logic [7:0]         lfsr_d;
    logic               busy_q;
    logic [19:0]        rx_q;
    logic [15:0]        err_q;
    logic               misroute_q;
    logic               seq_err_q;
    logic [W-1:0]       last_q;
    logic               seen_q [NUM_NODES];
    logic [SEQ-1:0]     exp_q  [NUM_NODES];

    logic [ADDR_BITS-1:0] src;
    logic [SEQ-1:0]       seq;
    logic [ADDR_BITS-1:0] dest;
    logic [SEQ-1:0]       seq_inc;
    logic                 accept;
    logic                 is_misroute;
    logic                 is_seq_err;
    logic                 flit_err;
    logic                 hit_seen;
    logic [SEQ-1:0]       hit_exp;

    function automatic logic [19:0] sat_inc20(input logic [19:0] v);
        return (v == '1) ? v : v + 20'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

    assign src     = data[W-1 -: ADDR_BITS];
    assign seq     = data[ADDR_BITS +: SEQ];
    assign dest    = data[ADDR_BITS-1:0];
    assign seq_inc = seq + SEQ'(1);

    // busy_q is already forced high outside RUN; the state term just makes the
    // acceptance rule self-evident.
    assign accept = valid && !busy_q && (state_q == S_RUN);

    // Fibonacci LFSR, taps 8,6,5,4 (maximal length, never reaches zero).
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // Table lookup by comparison loop so an out-of-range src never indexes
    // past the table. The table lives in flops, so a flit accepted on the
    // edge right after an update already sees the new exp value.
    always_comb begin
        hit_seen = 1'b0;
        hit_exp  = '0;
        for (int i = 0; i < NUM_NODES; i++) begin
            if (src == ADDR_BITS'(i)) begin
                hit_seen = seen_q[i];
                hit_exp  = exp_q[i];
            end
        end
    end

    always_comb begin
        is_misroute = (32'(src) >= 32'(NUM_NODES)) || (dest != ADDR_BITS'(NODE_ID));
        is_seq_err  = !is_misroute && hit_seen && (seq != hit_exp);
        flit_err    = is_misroute || is_seq_err;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_RESET;
            busy_q     <= 1'b1;
            lfsr_q     <= SEED;
            rx_q       <= '0;
            err_q      <= '0;
            misroute_q <= 1'b0;
            seq_err_q  <= 1'b0;
            last_q     <= '0;
            for (int i = 0; i < NUM_NODES; i++) begin
                seen_q[i] <= 1'b0;
            end
        end else begin
            unique case (state_q)
                S_RESET: begin
                    state_q <= S_RUN;
                    lfsr_q  <= lfsr_d;
                    busy_q  <= (lfsr_d > HOSP_B);
                end
                S_RUN: begin
                    lfsr_q <= lfsr_d;
                    busy_q <= (lfsr_d > HOSP_B);
                    if (accept) begin
                        rx_q   <= sat_inc20(rx_q);
                        last_q <= data;
                        if (is_misroute) begin
                            misroute_q <= 1'b1;
                        end else begin
                            // First-seen, in-order and resync all store seq+1.
                            for (int i = 0; i < NUM_NODES; i++) begin
                                if (src == ADDR_BITS'(i)) begin
                                    seen_q[i] <= 1'b1;
                                    exp_q[i]  <= seq_inc;
                                end
                            end
                        end
                        if (is_seq_err) begin
                            seq_err_q <= 1'b1;
                        end
                        if (flit_err) begin
                            err_q <= sat_inc16(err_q);
                        end
                        // Halt on the same edge as the erroneous acceptance.
                        if (flit_err && (STOP_ON_ERR != 0)) begin
                            state_q <= S_HALT;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    busy_q <= 1'b1;
                end
                default: begin
                    state_q <= S_RESET;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign rx_count  = rx_q;
    assign err_count = err_q;
    assign misroute  = misroute_q;
    assign seq_err   = seq_err_q;
    assign halted    = (state_q == S_HALT);
    assign last_flit = last_q;

endmodule

// File: tb/tb_par_checking_sink.sv
// Bench for par_checking_sink. Four instances share one clock:
//   0: NODE_ID=0, HOSP=255          (never busy; main function)
//   1: HOSP=0                       (always busy)
//   2: HOSP=128                     (random busy pattern)
//   3: HOSP=255, STOP_ON_ERR=1      (halt and recovery)
module tb_par_checking_sink;

    logic        clk = 1'b0;
    logic        reset [4];
    logic        valid [4];
    logic [15:0] data  [4];
    logic        busy  [4];
    logic [19:0] rx    [4];
    logic [15:0] err   [4];
    logic        mis   [4];
    logic        serr  [4];
    logic        halt  [4];
    logic [15:0] last  [4];

    int checks   = 0;
    int failures = 0;
    logic [15:0] sbq[$];

    always #5 clk = ~clk;

    par_checking_sink #(.NODE_ID(0), .HOSP(255), .STOP_ON_ERR(0)) dut0 (
        .clk(clk), .reset(reset[0]), .busy(busy[0]), .data(data[0]), .valid(valid[0]),
        .rx_count(rx[0]), .err_count(err[0]), .misroute(mis[0]), .seq_err(serr[0]),
        .halted(halt[0]), .last_flit(last[0]));

    par_checking_sink #(.NODE_ID(0), .HOSP(0), .STOP_ON_ERR(0)) dut1 (
        .clk(clk), .reset(reset[1]), .busy(busy[1]), .data(data[1]), .valid(valid[1]),
        .rx_count(rx[1]), .err_count(err[1]), .misroute(mis[1]), .seq_err(serr[1]),
        .halted(halt[1]), .last_flit(last[1]));

    par_checking_sink #(.NODE_ID(0), .HOSP(128), .STOP_ON_ERR(0)) dut2 (
        .clk(clk), .reset(reset[2]), .busy(busy[2]), .data(data[2]), .valid(valid[2]),
        .rx_count(rx[2]), .err_count(err[2]), .misroute(mis[2]), .seq_err(serr[2]),
        .halted(halt[2]), .last_flit(last[2]));

    par_checking_sink #(.NODE_ID(0), .HOSP(255), .STOP_ON_ERR(1)) dut3 (
        .clk(clk), .reset(reset[3]), .busy(busy[3]), .data(data[3]), .valid(valid[3]),
        .rx_count(rx[3]), .err_count(err[3]), .misroute(mis[3]), .seq_err(serr[3]),
        .halted(halt[3]), .last_flit(last[3]));

    function automatic logic [15:0] mk(input int src, input int seq, input int dest);
        return {4'(src), 8'(seq), 4'(dest)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input int d);
        chk($sformatf("d%0d rst busy", d),      32'(busy[d]), 32'd1);
        chk($sformatf("d%0d rst halted", d),    32'(halt[d]), 32'd0);
        chk($sformatf("d%0d rst misroute", d),  32'(mis[d]),  32'd0);
        chk($sformatf("d%0d rst seq_err", d),   32'(serr[d]), 32'd0);
        chk($sformatf("d%0d rst rx_count", d),  32'(rx[d]),   32'd0);
        chk($sformatf("d%0d rst err_count", d), 32'(err[d]),  32'd0);
        chk($sformatf("d%0d rst last_flit", d), 32'(last[d]), 32'd0);
    endtask

    // One reset edge with a valid flit presented (must not be accepted),
    // then release; returns just after the first edge in RUN.
    task automatic do_reset(input int d);
        @(negedge clk);
        reset[d] = 1'b0;
        valid[d] = 1'b1;
        data[d]  = mk(1, 0, 0);
        @(posedge clk);
        #1;
        valid[d] = 1'b0;
        chk_reset_vals(d);
        sbq.delete();
        @(negedge clk);
        reset[d] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Present one flit for one edge. Acceptance is predicted from busy as it
    // stands before the edge; accepted flits go through the scoreboard.
    task automatic send(input int d, input int src, input int seq, input int dest);
        logic [15:0] f;
        logic        b;
        int          rx0;
        @(negedge clk);
        f        = mk(src, seq, dest);
        b        = busy[d];
        rx0      = int'(rx[d]);
        data[d]  = f;
        valid[d] = 1'b1;
        if (!b) sbq.push_back(f);
        @(posedge clk);
        #1;
        valid[d] = 1'b0;
        if (!b) begin
            chk($sformatf("d%0d rx_inc", d), 32'(rx[d]), 32'(rx0 + 1));
            if (sbq.size() == 0) begin
                chk($sformatf("d%0d scoreboard_empty", d), 32'd1, 32'd0);
            end else begin
                chk($sformatf("d%0d last_flit", d), 32'(last[d]), 32'(sbq.pop_front()));
            end
        end else begin
            chk($sformatf("d%0d rx_hold", d), 32'(rx[d]), 32'(rx0));
        end
    endtask

    initial begin
        int          nb;
        int          acc;
        int          seqh;
        logic        b;
        logic [15:0] f;

        for (int i = 0; i < 4; i++) begin
            reset[i] = 1'b0;
            valid[i] = 1'b0;
            data[i]  = '0;
        end

        // ---------------- instance 0: basic in-order stream ----------------
        do_reset(0);
        chk("d0 busy_after_release", 32'(busy[0]), 32'd0);
        for (int s = 0; s < 5; s++) begin
            send(0, 3, s, 0);
            chk("d0 busy_stream", 32'(busy[0]), 32'd0);
        end
        chk("d0 rx5", 32'(rx[0]), 32'd5);
        chk("d0 err0", 32'(err[0]), 32'd0);
        chk("d0 mis0", 32'(mis[0]), 32'd0);
        chk("d0 serr0", 32'(serr[0]), 32'd0);
        chk("d0 last_seq4", 32'(last[0]), 32'(mk(3, 4, 0)));
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("d0 idle_no_accept", 32'(rx[0]), 32'd5);

        // ---------------- misroute ----------------
        do_reset(0);
        send(0, 3, 7, 2);
        chk("d0 mis_dest", 32'(mis[0]), 32'd1);
        send(0, 12, 0, 0);
        chk("d0 mis_err2", 32'(err[0]), 32'd2);
        chk("d0 mis_rx2", 32'(rx[0]), 32'd2);
        chk("d0 mis_serr0", 32'(serr[0]), 32'd0);
        send(0, 3, 0, 0);
        chk("d0 first_seen_after_mis", 32'(err[0]), 32'd2);
        send(0, 3, 1, 0);
        chk("d0 in_order_after_mis", 32'(err[0]), 32'd2);
        chk("d0 serr_after_mis", 32'(serr[0]), 32'd0);

        // ---------------- sequence error and resync ----------------
        do_reset(0);
        send(0, 1, 5, 0);
        send(0, 1, 6, 0);
        chk("d0 seq_ok_err", 32'(err[0]), 32'd0);
        chk("d0 seq_ok_flag", 32'(serr[0]), 32'd0);
        send(0, 1, 8, 0);
        chk("d0 seq_gap_err", 32'(err[0]), 32'd1);
        chk("d0 seq_gap_flag", 32'(serr[0]), 32'd1);
        chk("d0 seq_gap_mis", 32'(mis[0]), 32'd0);
        send(0, 1, 9, 0);
        chk("d0 resync_err", 32'(err[0]), 32'd1);
        chk("d0 resync_rx", 32'(rx[0]), 32'd4);

        // ---------------- sequence wrap-around ----------------
        do_reset(0);
        send(0, 4, 255, 0);
        send(0, 4, 0, 0);
        send(0, 4, 1, 0);
        chk("d0 wrap_err", 32'(err[0]), 32'd0);
        chk("d0 wrap_rx", 32'(rx[0]), 32'd3);
        chk("d0 wrap_serr", 32'(serr[0]), 32'd0);

        // ---------------- instance 1: always busy ----------------
        do_reset(1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            valid[1] = 1'b1;
            data[1]  = mk(2, i, 0);
            @(posedge clk);
            #1;
            chk("d1 busy_always", 32'(busy[1]), 32'd1);
        end
        valid[1] = 1'b0;
        chk("d1 rx_zero", 32'(rx[1]), 32'd0);

        // ---------------- instance 2: random busy ----------------
        do_reset(2);
        nb   = 0;
        acc  = 0;
        seqh = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            b        = busy[2];
            f        = mk(2, seqh, 0);
            data[2]  = f;
            valid[2] = 1'b1;
            if (!b) sbq.push_back(f);
            else nb++;
            @(posedge clk);
            #1;
            if (!b) begin
                acc++;
                seqh++;
                if (sbq.size() == 0) chk("d2 scoreboard_empty", 32'd1, 32'd0);
                else chk("d2 last_flit", 32'(last[2]), 32'(sbq.pop_front()));
            end
            chk("d2 rx_model", 32'(rx[2]), 32'(acc));
        end
        valid[2] = 1'b0;
        chk("d2 err0", 32'(err[2]), 32'd0);
        chk("d2 duty_about_half", 32'((nb >= 50) && (nb <= 150)), 32'd1);

        // ---------------- instance 3: halt and recovery ----------------
        do_reset(3);
        send(3, 1, 0, 5);
        chk("d3 halted", 32'(halt[3]), 32'd1);
        chk("d3 busy_halt", 32'(busy[3]), 32'd1);
        chk("d3 rx1", 32'(rx[3]), 32'd1);
        chk("d3 err1", 32'(err[3]), 32'd1);
        for (int i = 0; i < 3; i++) send(3, 2, i, 0);
        chk("d3 halted_hold", 32'(halt[3]), 32'd1);
        chk("d3 busy_hold", 32'(busy[3]), 32'd1);
        chk("d3 rx_frozen", 32'(rx[3]), 32'd1);
        chk("d3 err_frozen", 32'(err[3]), 32'd1);
        chk("d3 mis_sticky", 32'(mis[3]), 32'd1);
        do_reset(3);
        chk("d3 busy_resume", 32'(busy[3]), 32'd0);
        send(3, 2, 0, 0);
        chk("d3 resume_rx", 32'(rx[3]), 32'd1);
        chk("d3 resume_err", 32'(err[3]), 32'd0);
        chk("d3 resume_halted", 32'(halt[3]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
